// File: rtl/pipe_stage_skid.sv
// Two-entry ready/valid skid pipeline stage with flush and saturating stall counter.
// in_ready depends only on held state, so back-pressure never forms a combinational path upstream.
module pipe_stage_skid #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              accept;
  logic              issue;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (v == {CNT_W{1'b1}}) ? v : v + one;
  endfunction

  assign in_ready    = (state_q != TWO) & ~reset;
  assign accept      = in_valid & in_ready;
  assign issue       = valid_q & out_ready;
  assign out_valid   = valid_q;
  assign out_data    = main_data_q;
  assign out_ctrl    = main_ctrl_q;
  assign occupancy   = state_q;
  assign stall_count = stall_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    stall_d     = (valid_q & ~out_ready) ? sat_inc(stall_q) : stall_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          valid_d     = 1'b1;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      ONE: begin
        if (accept && !issue) begin
          state_d     = TWO;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end else if (issue && !accept) begin
          state_d     = EMPTY;
          valid_d     = 1'b0;
          main_ctrl_d = '0;
        end else if (accept && issue) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      TWO: begin
        if (issue) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_ctrl_d = '0;
        end
      end
      default: begin
        state_d     = EMPTY;
        valid_d     = 1'b0;
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
      end
    endcase

    // Squash wins over everything; payload bits are left as they are.
    if (flush) begin
      state_d     = EMPTY;
      valid_d     = 1'b0;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      valid_q     <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
    end
  end

  // Skid payload is only ever observed after being loaded, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: vector table plus hand sequences, FIFO scoreboard for payload order.
module tb_pipe_stage_skid;
  localparam int DATA_W = 16;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_count;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_count(stall_count)
  );

  typedef struct {
    bit          rst;
    bit          iv;
    logic [15:0] d;
    logic [7:0]  c;
    bit          ordy;
    bit          fl;
    logic [1:0]  exp_occ;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
  } word_t;

  vec_t  tbl[$];
  word_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_stall = 0;

  function automatic vec_t mk(bit r, bit iv, logic [15:0] d, logic [7:0] c,
                              bit o, bit f, logic [1:0] occ);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.c = c; v.ordy = o; v.fl = f; v.exp_occ = occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    #1;
    chk({tag, "_rst_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rst_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_rst_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_rst_out_ctrl"}, 32'(out_ctrl), 32'd0);
    chk({tag, "_rst_occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, "_rst_stall"}, 32'(stall_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    exp_stall = 0;
  endtask

  task automatic step(input vec_t v, input string tag);
    bit    exp_rdy;
    bit    nonempty;
    word_t w;
    in_valid = v.iv; in_data = v.d; in_ctrl = v.c; out_ready = v.ordy; flush = v.fl;
    @(negedge clk);
    nonempty = (sb.size() != 0);
    exp_rdy  = (sb.size() != 2);
    chk({tag, "_occ"}, 32'(occupancy), 32'(v.exp_occ));
    chk({tag, "_occ_sb"}, 32'(occupancy), 32'(sb.size()));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(nonempty));
    chk({tag, "_stall"}, 32'(stall_count), 32'(exp_stall));
    if (nonempty) begin
      chk({tag, "_out_data"}, 32'(out_data), 32'(sb[0].d));
      chk({tag, "_out_ctrl"}, 32'(out_ctrl), 32'(sb[0].c));
    end else begin
      chk({tag, "_out_ctrl_idle"}, 32'(out_ctrl), 32'd0);
    end
    if (nonempty && !v.ordy && exp_stall < SAT) exp_stall++;
    if (nonempty && v.ordy) void'(sb.pop_front());
    if (v.fl) sb.delete();
    else if (v.iv && exp_rdy) begin
      w.d = v.d; w.c = v.c;
      sb.push_back(w);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;

    // streaming at full rate
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(i == 1, 1'b1, 16'(i), 8'(8'h10 + i), 1'b1, 1'b0, (i == 1) ? 2'd0 : 2'd1));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 1, 0, 2'd1));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 1, 0, 2'd0));
    // back-pressure, offer at full is refused
    tbl.push_back(mk(1, 1, 16'h00A1, 8'h31, 0, 0, 2'd0));
    tbl.push_back(mk(0, 1, 16'h00A2, 8'h32, 0, 0, 2'd1));
    tbl.push_back(mk(0, 1, 16'h0BAD, 8'hBB, 0, 0, 2'd2));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 0, 0, 2'd2));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 1, 0, 2'd2));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 1, 0, 2'd1));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 1, 0, 2'd0));
    // accept and issue together in ONE
    tbl.push_back(mk(1, 1, 16'h00B1, 8'h41, 1, 0, 2'd0));
    tbl.push_back(mk(0, 1, 16'h00B2, 8'h42, 1, 0, 2'd1));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 1, 0, 2'd1));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 1, 0, 2'd0));
    // flush at two entries, then at one entry with in_ready high
    tbl.push_back(mk(1, 1, 16'h00C1, 8'h51, 0, 0, 2'd0));
    tbl.push_back(mk(0, 1, 16'h00C2, 8'h52, 0, 0, 2'd1));
    tbl.push_back(mk(0, 1, 16'h00FF, 8'hFF, 0, 1, 2'd2));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 0, 0, 2'd0));
    tbl.push_back(mk(0, 1, 16'h00D1, 8'h61, 0, 0, 2'd0));
    tbl.push_back(mk(0, 1, 16'h00FF, 8'hFF, 0, 1, 2'd1));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 0, 0, 2'd0));
    tbl.push_back(mk(0, 1, 16'h00D2, 8'h62, 1, 0, 2'd0));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 1, 0, 2'd1));
    tbl.push_back(mk(0, 0, 16'hDEAD, 8'hEE, 1, 0, 2'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset($sformatf("v%0d", i));
      step(tbl[i], $sformatf("v%0d", i));
    end

    // stall counter saturation
    do_reset("sat");
    step(mk(0, 1, 16'h00E1, 8'h71, 0, 0, 2'd0), "sat_push");
    for (int k = 0; k < 20; k++)
      step(mk(0, 0, 16'hDEAD, 8'hEE, 0, 0, 2'd1), $sformatf("sat%0d", k));
    chk("sat_final", 32'(stall_count), 32'(SAT));

    // asynchronous reset while holding two entries
    do_reset("ar");
    step(mk(0, 1, 16'h00F1, 8'h81, 0, 0, 2'd0), "ar0");
    step(mk(0, 1, 16'h00F2, 8'h82, 0, 0, 2'd1), "ar1");
    step(mk(0, 0, 16'hDEAD, 8'hEE, 0, 0, 2'd2), "ar2");
    chk("ar_pre_stall", 32'(stall_count), 32'd2);
    do_reset("ar_mid");
    step(mk(0, 1, 16'h00F3, 8'h83, 1, 0, 2'd0), "ar3");
    step(mk(0, 0, 16'hDEAD, 8'hEE, 1, 0, 2'd1), "ar4");
    step(mk(0, 0, 16'hDEAD, 8'hEE, 1, 0, 2'd0), "ar5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
